// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) memory arbiter and responder with round-robin selection,
// one access in flight at a time, and an internal word RAM with fixed latency.
module mem_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 1024,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_grant,
   output logic                  if_data_valid,
   output logic [DATA_WIDTH-1:0] if_rd_data,
   input  logic                  d_req_valid,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic                  d_we,
   input  logic [DATA_WIDTH-1:0] d_wrt_data,
   output logic                  d_grant,
   output logic                  d_data_valid,
   output logic [DATA_WIDTH-1:0] d_rd_data,
   output logic                  addr_err,
   output logic [1:0]            state_dbg
);

   // Handshake: a requester holds req_valid, address and data stable until its
   // one-cycle grant; after grant only the captured copies are used, and the
   // matching data_valid pulse (one cycle) marks completion of that access.

   localparam int   IDX_W   = $clog2(DEPTH);
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                state;
   state_t                next_state;
   logic                  last_served;
   logic [3:0]            cnt;

   logic                  cap_port;
   logic                  cap_we;
   logic                  cap_oor;
   logic [IDX_W-1:0]      cap_idx;
   logic [DATA_WIDTH-1:0] cap_wdata;

   logic [DATA_WIDTH-1:0] ram [DEPTH];

   logic                  any_req;
   logic                  win_port;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic                  win_we;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic                  win_oor;
   logic [DATA_WIDTH-1:0] resp_rd;
   logic                  unused_addr_lsbs;

   // On a tie the port that was not served last wins.
   always_comb begin
      any_req = if_req_valid | d_req_valid;
      if (if_req_valid && d_req_valid) begin
         win_port = ~last_served;
      end else begin
         win_port = d_req_valid;
      end
      win_addr  = win_port ? d_addr : if_addr;
      win_we    = win_port & d_we;
      win_wdata = win_port ? d_wrt_data : '0;
      win_oor   = (win_addr[ADDR_WIDTH-1:IDX_W+2] != '0);
   end

   assign unused_addr_lsbs = ^win_addr[1:0];

   // Stores and out-of-range reads return zero on the read-data bus.
   assign resp_rd = (cap_we || cap_oor) ? '0 : ram[cap_idx];

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_req) next_state = GRANT;
         GRANT:   next_state = (MEM_LATENCY > 1) ? WAIT : RESP;
         WAIT:    if (cnt == 4'd1) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_served   <= PORT_IF;
         cnt           <= '0;
         cap_port      <= PORT_IF;
         cap_we        <= 1'b0;
         cap_oor       <= 1'b0;
         cap_idx       <= '0;
         cap_wdata     <= '0;
         if_grant      <= 1'b0;
         d_grant       <= 1'b0;
         if_data_valid <= 1'b0;
         d_data_valid  <= 1'b0;
         addr_err      <= 1'b0;
         if_rd_data    <= '0;
         d_rd_data     <= '0;
      end else begin
         if_grant      <= 1'b0;
         d_grant       <= 1'b0;
         if_data_valid <= 1'b0;
         d_data_valid  <= 1'b0;
         addr_err      <= 1'b0;

         if (state == IDLE && any_req) begin
            cap_port  <= win_port;
            cap_we    <= win_we;
            cap_oor   <= win_oor;
            cap_idx   <= win_addr[IDX_W+1:2];
            cap_wdata <= win_wdata;
            if_grant  <= (win_port == PORT_IF);
            d_grant   <= (win_port == PORT_D);
         end

         if (state == GRANT) begin
            cnt <= 4'(MEM_LATENCY - 1);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end

         // Response outputs are registered on the edge that enters RESP.
         if (next_state == RESP) begin
            addr_err <= cap_oor;
            if (cap_port == PORT_D) begin
               d_data_valid <= 1'b1;
               d_rd_data    <= resp_rd;
            end else begin
               if_data_valid <= 1'b1;
               if_rd_data    <= resp_rd;
            end
         end

         if (state == RESP) begin
            last_served <= cap_port;
         end
      end
   end

   // The store lands on the edge ending RESP; reset on that edge aborts it.
   always_ff @(posedge clk) begin
      if (!reset && state == RESP && cap_we && !cap_oor) begin
         ram[cap_idx] <= cap_wdata;
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory arbiter and responder: the slave end of the request/grant/data_valid protocol that the execution stage's load/store unit and the fetch stage drive. It accepts requests from two ports (instruction fetch, read-only; data, read/write), arbitrates round-robin, services one request at a time against an internal word-addressed RAM with configurable fixed latency, and returns data or write completion to the winning port.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- DEPTH, 1024, RAM depth in words (power of two)
- MEM_LATENCY, 2, cycles from grant to response (legal range 1..15)

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- if_req_valid  in  1  fetch request
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_grant  out  1  fetch request accepted
- if_data_valid  out  1  fetch response strobe
- if_rd_data  out  DATA_WIDTH  fetch read data
- d_req_valid  in  1  data request
- d_addr  in  ADDR_WIDTH  data byte address
- d_we  in  1  1 = store, 0 = load
- d_wrt_data  in  DATA_WIDTH  store data
- d_grant  out  1  data request accepted
- d_data_valid  out  1  data response strobe (loads and stores)
- d_rd_data  out  DATA_WIDTH  load data
- addr_err  out  1  out-of-range access flag, coincides with the response strobe

## Operation
- FSM states: IDLE, GRANT, WAIT, RESP.
- IDLE: sample both req_valid signals. If neither is set, stay. If one is set, select it. If both are set, select the port not served last. `last_served` resets to fetch, so data wins the first tie.
- IDLE->GRANT: capture the winner's port id, addr, we, and wrt_data into registers. Fetch requests capture we=0.
- GRANT: assert the winner's grant for exactly 1 cycle. Go to WAIT if MEM_LATENCY>1, else go to RESP. Load the counter with MEM_LATENCY-1.
- WAIT: decrement the counter each cycle. Go to RESP when the count reaches 1.
- RESP: assert the winner's data_valid for exactly 1 cycle, then update last_served and return to IDLE.
  - Read data is driven from RAM[captured_addr[log2(DEPTH)+1:2]].
  - A store writes RAM on the clock edge ending RESP. rd_data is then don't-care; drive 0.
- Address handling:
  - addr[1:0] is ignored (word access only).
  - An address is out of range when addr >= DEPTH*4. In that case:
    - a read returns 0,
    - a write is dropped,
    - addr_err=1 during RESP.
- Requester rules:
  - A requester holds req_valid and its address/data stable until grant.
  - After grant, inputs are don't-care, because the arbiter uses only the captured copies.
  - A port's req_valid is ignored while that port has a request in flight.
  - A port may re-request from the cycle after its data_valid.
- Ordering: one outstanding request total. A store followed by a load to the same address returns the stored value.
- RAM is not cleared by reset.

## Timing
- All outputs are registered. Reset values:
  - if_grant, d_grant, if_data_valid, d_data_valid, addr_err = 0
  - if_rd_data, d_rd_data = 0
  - state = IDLE, last_served = fetch
- Request first sampled high in IDLE at cycle T:
  - grant is high at T+1,
  - data_valid is high at T+1+MEM_LATENCY.
- Back-to-back requests: the FSM is back in IDLE at T+2+MEM_LATENCY, and the next grant comes no earlier than T+3+MEM_LATENCY. Throughput is one access per MEM_LATENCY+2 cycles.
- rd_data is valid only in the data_valid cycle. Outside that cycle it holds its last value.
- A request arriving while state != IDLE waits and is sampled on return to IDLE.
- Reset in any state:
  - go to IDLE next cycle and force all outputs to reset values,
  - abort the in-flight access; a pending store is not written.
- grant and data_valid are never high on both ports in the same cycle. grant and data_valid are never high in the same cycle.

## Test plan
- Store then load, MEM_LATENCY=2:
  - d_req_valid, d_we=1, d_addr=0x10, d_wrt_data=0xDEADBEEF at T -> d_grant at T+1, d_data_valid at T+3.
  - Then load 0x10 -> d_rd_data=0xDEADBEEF with d_data_valid, addr_err=0.
- Simultaneous requests from reset, both held: fetch 0x10, data load 0x20 -> data granted first. Fetch is granted at T+5 after data's strobe at T+3; alternation continues with both requests held.
- Out of range, DEPTH=1024: store 0x55 to 0x1000 -> addr_err=1 with d_data_valid. A load of 0x1000 -> rd_data=0, addr_err=1. A load of 0x0 is unaffected.
- Misalignment: store 0x12345678 to 0x8, load from 0xB -> 0x12345678.
- Reset mid-access: assert reset during WAIT of a store to 0x40 -> all outputs 0 next cycle, no data_valid. A later load of 0x40 returns the prior contents.
- MEM_LATENCY=1 sweep: grant at T+1, data_valid at T+2. Input changes after grant do not alter the result.
